// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding, parity mode codes and frame-length limits.
// Shared by the UART transmitter and the future receiver.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;
   localparam int MIN_NBITS = 5;
   function automatic logic [3:0] clamp_nbits(input logic [3:0] n, input int max_n);
      return (32'(n) < MIN_NBITS) ? 4'(MIN_NBITS) : (32'(n) > max_n) ? 4'(max_n) : n;
   endfunction
endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: payload, per-frame mode and valid/ready handshake into the UART transmitter.
interface uart_tx_cfg_if #(parameter int NB_DATA = 9);
   logic [NB_DATA-1:0] i_data;
   logic [3:0]         i_nbits;
   logic [1:0]         i_parity;
   logic               i_stop2;
   logic               i_valid;
   logic               o_ready;
   modport master (output i_data, i_nbits, i_parity, i_stop2, i_valid, input o_ready);
   modport slave  (input i_data, i_nbits, i_parity, i_stop2, i_valid, output o_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: baud tick counter; one-cycle tick every i_cmp+1 enabled cycles, restarted by i_clr.
module uart_baud_gen #(
   parameter int NB_COUNTER = 9
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_clr,
   input  logic                  i_en,
   input  logic [NB_COUNTER-1:0] i_cmp,
   output logic                  o_tick
);
   logic [NB_COUNTER-1:0] cnt_q, cnt_d;
   assign o_tick = i_en && !i_clr && cnt_q == i_cmp;
   assign cnt_d = (i_clr || o_tick) ? '0 : i_en ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or negedge i_rst)
      if (!i_rst) cnt_q <= '0;
      else        cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter (5..NB_DATA bits, none/even/odd parity, 1/2 stops).
// Define UART_TX_BREAK_EN to add the i_break line-break input.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int NB_DATA      = 9,
   parameter int NB_COUNTER   = 9,
   parameter int N_OVERSAMPLE = 16
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic [NB_COUNTER-1:0] i_tick_cmp,
`ifdef UART_TX_BREAK_EN
   input  logic                  i_break,
`endif
   uart_tx_cfg_if.slave          bus,
   output logic                  o_tx,
   output logic                  o_busy,
   output logic                  o_done
);
   localparam int NB_OS = $clog2(N_OVERSAMPLE + 1);
   state_e             state_q, state_d;
   logic [NB_DATA-1:0] sh_q, sh_d, mask;
   logic [3:0]         nb_q, nb_d, bit_q, bit_d, nb_c;
   logic [1:0]         mode_q, mode_d;
   logic [NB_OS-1:0]   os_q, os_d;
   logic               par_q, par_d, stop2_q, stop2_d, done_q, done_d;
   logic               brk, tick, bit_end, accept;
`ifdef UART_TX_BREAK_EN
   assign brk = i_break;
`else
   assign brk = 1'b0;
`endif
   assign bus.o_ready = state_q == IDLE && !brk;
   assign o_busy      = !bus.o_ready;
   assign o_done      = done_q;
   assign accept      = bus.i_valid && bus.o_ready;
   assign nb_c        = clamp_nbits(bus.i_nbits, NB_DATA);
   assign mask        = NB_DATA'((32'd1 << nb_c) - 32'd1);
   // os_q counts baud ticks within the current bit period
   assign bit_end     = tick && os_q == NB_OS'(N_OVERSAMPLE - 1);
   assign os_d        = (accept || bit_end) ? '0 : tick ? os_q + 1'b1 : os_q;
   uart_baud_gen #(.NB_COUNTER(NB_COUNTER)) u_baud (
      .clk    (clk),
      .i_rst  (i_rst),
      .i_clr  (accept),
      .i_en   (state_q != IDLE),
      .i_cmp  (i_tick_cmp),
      .o_tick (tick)
   );
   always_comb begin
      o_tx = 1'b1;
      case (state_q)
         IDLE:    o_tx = !brk;
         START:   o_tx = 1'b0;
         DATA:    o_tx = sh_q[0];
         PARITY:  o_tx = par_q;
         default: o_tx = 1'b1;
      endcase
   end
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      nb_d    = nb_q;
      bit_d   = bit_q;
      mode_d  = mode_q;
      par_d   = par_q;
      stop2_d = stop2_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            state_d = START;
            sh_d    = bus.i_data;
            nb_d    = nb_c;
            bit_d   = '0;
            mode_d  = (bus.i_parity == PAR_EVEN || bus.i_parity == PAR_ODD) ? bus.i_parity : PAR_NONE;
            par_d   = ^(bus.i_data & mask) ^ (bus.i_parity == PAR_ODD);
            stop2_d = bus.i_stop2;
         end
         START: if (bit_end) state_d = DATA;
         DATA: if (bit_end) begin
            sh_d  = sh_q >> 1;
            bit_d = bit_q + 1'b1;
            if (bit_q == nb_q - 1'b1) begin
               state_d = (mode_q == PAR_NONE) ? STOP : PARITY;
               bit_d   = '0;
            end
         end
         PARITY: if (bit_end) state_d = STOP;
         STOP: if (bit_end) begin
            bit_d = bit_q + 1'b1;
            if (!stop2_q || bit_q != '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge i_rst)
      if (!i_rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         nb_q    <= '0;
         bit_q   <= '0;
         mode_q  <= PAR_NONE;
         par_q   <= 1'b0;
         stop2_q <= 1'b0;
         done_q  <= 1'b0;
         os_q    <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         nb_q    <= nb_d;
         bit_q   <= bit_d;
         mode_q  <= mode_d;
         par_q   <= par_d;
         stop2_q <= stop2_d;
         done_q  <= done_d;
         os_q    <= os_d;
      end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: randomized frames checked cycle by cycle against a serial-bit-list reference model.
// Covers the UART_TX_BREAK_EN variant when that macro is defined.
module tb_uart_tx_cfg;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [8:0] tick_cmp = '0;
   logic       tx, busy, done;
   int         n_vec = 0;
   int         n_err = 0;
`ifdef UART_TX_BREAK_EN
   logic       brk = 1'b0;
`endif
   uart_tx_cfg_if #(.NB_DATA(9)) bus ();
   uart_tx_cfg #(.NB_DATA(9), .NB_COUNTER(9), .N_OVERSAMPLE(16)) dut (
      .clk        (clk),
      .i_rst      (rst_n),
      .i_tick_cmp (tick_cmp),
`ifdef UART_TX_BREAK_EN
      .i_break    (brk),
`endif
      .bus        (bus),
      .o_tx       (tx),
      .o_busy     (busy),
      .o_done     (done)
   );
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s {tx,busy,ready,done} got=%b exp=%b at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int eff_n(input int n);
      return n < 5 ? 5 : n > 9 ? 9 : n;
   endfunction

   // Called at a negedge while idle; returns at the negedge of the first idle (o_done) cycle.
   task automatic send(input logic [8:0] d, input logic [3:0] n, input logic [1:0] p, input logic s2, input bit hold);
      int ne = eff_n(int'(n));
      int per = 16 * (int'(tick_cmp) + 1);
      bit q[$];
      bit par = 1'b0;
      q.push_back(1'b0);
      for (int j = 0; j < ne; j++) begin
         q.push_back(d[j]);
         par ^= d[j];
      end
      if (p == 2'b01 || p == 2'b10) q.push_back(par ^ (p == 2'b10));
      q.push_back(1'b1);
      if (s2) q.push_back(1'b1);
      bus.i_data = d;
      bus.i_nbits = n;
      bus.i_parity = p;
      bus.i_stop2 = s2;
      bus.i_valid = 1'b1;
      chk("accept_ready", {tx, busy, bus.o_ready, done} & 4'b0010, 4'b0010);
      @(posedge clk);
      @(negedge clk);
      bus.i_valid = hold;
      bus.i_data = 9'($urandom);
      bus.i_nbits = 4'($urandom);
      bus.i_parity = 2'($urandom);
      bus.i_stop2 = 1'($urandom);
      for (int i = 0; i < q.size() * per; i++) begin
         chk("frame", {tx, busy, bus.o_ready, done}, {q[i / per], 3'b100});
         @(negedge clk);
      end
      chk("done", {tx, busy, bus.o_ready, done}, 4'b1011);
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(negedge clk);
         chk("idle", {tx, busy, bus.o_ready, done}, 4'b1010);
      end
   endtask

   initial begin
      bus.i_data = '0;
      bus.i_nbits = 4'd8;
      bus.i_parity = 2'b00;
      bus.i_stop2 = 1'b0;
      bus.i_valid = 1'b0;
      #3 chk("reset", {tx, busy, bus.o_ready, done}, 4'b1010);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      // directed frames
      tick_cmp = 9'd0;
      send(9'h0A5, 4'd8, 2'b00, 1'b0, 1'b0);
      idle(2);
      tick_cmp = 9'd2;
      send(9'h003, 4'd7, 2'b01, 1'b1, 1'b0);
      idle(1);
      tick_cmp = 9'd0;
      send(9'h1FF, 4'd9, 2'b10, 1'b0, 1'b0);
      idle(1);
      send(9'h1EB, 4'd3, 2'b01, 1'b0, 1'b0);
      idle(1);
      send(9'h16D, 4'd15, 2'b10, 1'b1, 1'b0);
      idle(1);
      send(9'h055, 4'd8, 2'b00, 1'b0, 1'b1);
      send(9'h0AA, 4'd8, 2'b00, 1'b0, 1'b0);
      idle(2);
      // asynchronous reset in the middle of data bit 4
      bus.i_data = 9'h000;
      bus.i_nbits = 4'd8;
      bus.i_parity = 2'b00;
      bus.i_stop2 = 1'b0;
      bus.i_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_valid = 1'b0;
      repeat (16 * 5 + 7) @(negedge clk);
      chk("pre_rst", {tx, busy, bus.o_ready, done}, 4'b0100);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", {tx, busy, bus.o_ready, done}, 4'b1010);
      repeat (3) begin
         @(negedge clk);
         chk("rst_hold", {tx, busy, bus.o_ready, done}, 4'b1010);
      end
      rst_n = 1'b1;
      idle(3);
      send(9'h0C3, 4'd8, 2'b01, 1'b0, 1'b0);
      idle(2);
`ifdef UART_TX_BREAK_EN
      brk = 1'b1;
      bus.i_data = 9'h13C;
      bus.i_valid = 1'b1;
      repeat (300) begin
         @(negedge clk);
         chk("break", {tx, busy, bus.o_ready, done}, 4'b0100);
      end
      brk = 1'b0;
      send(9'h13C, 4'd8, 2'b01, 1'b0, 1'b0);
      idle(2);
`endif
      // randomized frames, some back-to-back with i_valid held
      for (int k = 0; k < 25; k++) begin
         bit hold = ($urandom_range(0, 3) == 0) && k < 24;
         tick_cmp = 9'($urandom_range(0, 2));
         send(9'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), hold);
         if (!hold) idle($urandom_range(1, 4));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised, runtime-configurable UART transmitter; successor to the fixed 8N1 transmit path in the UART0 instance.
- Embedded baud tick generator driven by a programmable compare value.
- Per-frame selectable data length, parity mode and stop-bit count, plus a valid/ready input handshake.
- Sits between the CPU subsystem's UART write port and the o_RsTx pin.

Parameters:
NB_DATA, 9, max data bits per frame; must be >= 5
NB_COUNTER, 9, width of baud tick counter and i_tick_cmp
N_OVERSAMPLE, 16, baud ticks per bit period

Ports:
clk  input  1  system clock
i_rst  input  1  asynchronous, active-low reset
i_tick_cmp  input  NB_COUNTER  tick period minus one, in clk cycles
i_nbits  input  4  data bits per frame; clamped to [5, NB_DATA]
i_parity  input  2  00 none, 01 even, 10 odd, 11 none
i_stop2  input  1  1 = two stop bits, 0 = one
i_data  input  NB_DATA  frame payload, LSB transmitted first
i_valid  input  1  payload/mode valid
o_ready  output  1  idle, can accept
o_tx  output  1  serial line, idle high
o_busy  output  1  frame in progress
o_done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset is active-low, async, and applies at any time, including mid-frame. Output values during reset:
  - o_tx=1, o_ready=1, o_busy=0, o_done=0
  - FSM in IDLE, counters 0
- Tick generator:
  - Counter increments every clk while busy.
  - When counter == i_tick_cmp: counter -> 0 and a tick pulses for one cycle. Tick period is i_tick_cmp+1 cycles; i_tick_cmp=0 gives a tick every cycle.
  - Counter and tick-in-bit counter clear on acceptance, so every bit lasts exactly N_OVERSAMPLE*(i_tick_cmp+1) cycles.
- i_tick_cmp is sampled live. Changing it mid-frame is legal but frame timing is undefined for the affected bit.
- Handshake:
  - o_ready = (state==IDLE).
  - Accept on the rising clk edge where i_valid && o_ready.
  - On accept, latch i_data, clamped i_nbits, i_parity and i_stop2. Mode inputs are ignored at all other times.
- FSM states and transitions:
  - IDLE -> START on accept. o_tx drives 0 from the cycle after accept.
  - START -> DATA after 1 bit period.
  - DATA: shift out LSB first, 1 bit period each, for nbits bits. Then go to PARITY if the latched parity is 01 or 10, else to STOP.
  - PARITY: one bit period.
    - Even mode: XOR of the nbits transmitted bits.
    - Odd mode: its inverse.
    - Bits above nbits are excluded from the XOR.
  - STOP: o_tx=1 for 1 or 2 bit periods, then -> IDLE.
- o_done pulses for exactly one cycle, coincident with the first IDLE cycle (o_ready=1). o_busy = !o_ready.
- Back-to-back: with i_valid held high, the next frame is accepted in that first IDLE cycle. The gap between stop bit and next start bit is exactly 1 clk.
- Frame length in bit periods = 1 + nbits + (parity?1:0) + (stop2?2:1).
- Clamp: i_nbits < 5 -> 5; i_nbits > NB_DATA -> NB_DATA.

Optional Feature:
UART_TX_BREAK_EN.
- Defined:
  - Adds input i_break (1 bit).
  - While i_break=1 in IDLE: o_tx=0, o_ready=0, o_busy=1; the accept path is blocked.
  - Release returns to IDLE with o_tx=1 the next cycle. No o_done is generated for a break.
  - i_break asserted mid-frame is ignored until the frame completes.
- Undefined: no i_break port; behaviour exactly as above.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (IDLE/START/DATA/PARITY/STOP)
  - parity mode constants (PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10)
  - MIN_NBITS=5
- One sub-module, uart_baud_gen: tick counter with clear and enable inputs, reusable by the future receiver.

Test Plan:
- 8N1 frame: i_tick_cmp=0, nbits=8, parity=00, stop2=0, data=0xA5 -> 160-cycle frame. Serial sequence 0,1,0,1,0,0,1,0,1,1; o_done pulses 1 cycle at cycle 161.
- 7E2 frame: i_tick_cmp=2, nbits=7, parity=01, stop2=1, data=0x03 -> parity bit 0. 11 bit periods of 48 cycles (528 cycles total).
- Odd parity, clamped length: 9O1, data=0x1FF -> parity bit 0. i_nbits=3 -> 5-bit frame sending data[4:0]. i_nbits=15 -> 9-bit frame.
- Back-to-back: i_valid held with 0x55 then 0xAA, 8N1 -> exactly 1 high cycle between the two frames. o_done pulses twice; mode changes applied only at accept.
- Reset mid-DATA: assert i_rst=0 at bit 4 -> o_tx=1, o_ready=1, o_busy=0 asynchronously, with no o_done. After release, the next frame transmits cleanly.
- With UART_TX_BREAK_EN: i_break=1 for 300 cycles -> o_tx=0 and o_ready=0 throughout. A pending i_valid frame starts after release.
